// File: rtl/adc_average_multi_if.sv
// Sample-stream and result handshake bundle for the multi-channel block averager.
// The master drives the controls and samples; the slave (averager) returns results.
interface adc_average_multi_if #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 2
);
    logic                        en;
    logic                        continuous;
    logic [NUM_CH*ADC_WIDTH-1:0] data_in;
    logic                        in_valid;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_CH*ADC_WIDTH-1:0] data_out;
    logic                        busy;
    logic                        overrun;

    modport master (
        output en, continuous, data_in, in_valid, out_ready,
        input  out_valid, data_out, busy, overrun
    );

    modport slave (
        input  en, continuous, data_in, in_valid, out_ready,
        output out_valid, data_out, busy, overrun
    );
endinterface

// File: rtl/adc_average_multi.sv
// Multi-channel block averager: sums 2^LOG2_SAMPS accepted samples per channel in lockstep
// and presents each channel's floor mean through a registered valid/ready result port.
module adc_average_multi #(
    parameter int ADC_WIDTH  = 12,
    parameter int NUM_CH     = 2,
    parameter int LOG2_SAMPS = 10,
    parameter bit SIGNED_IN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    adc_average_multi_if.slave bus
);
    localparam int ACC_W = ADC_WIDTH + LOG2_SAMPS;
    localparam int CNT_W = LOG2_SAMPS + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_SAMPS) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                      state_q;
    logic                        cont_q;
    logic                        busy_q;
    logic                        out_valid_q;
    logic                        overrun_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [ACC_W-1:0]            acc_q [NUM_CH];
    logic [NUM_CH*ADC_WIDTH-1:0] data_out_q;

    logic [ACC_W-1:0]            acc_d [NUM_CH];
    logic [NUM_CH*ADC_WIDTH-1:0] mean_d;
    logic                        last_s;
    logic                        load_s;

    function automatic logic [ACC_W-1:0] extend_sample(input logic [ADC_WIDTH-1:0] samp);
        logic fill;
        fill = SIGNED_IN ? samp[ADC_WIDTH-1] : 1'b0;
        return {{LOG2_SAMPS{fill}}, samp};
    endfunction

    // Running sums including the current sample, and the means they would produce.
    // The accumulator is exactly LOG2_SAMPS bits wider than a sample, so its top ADC_WIDTH
    // bits equal the low bits of the (arithmetic or logical) shift: a floor divide.
    always_comb begin
        mean_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = acc_q[c] + extend_sample(bus.data_in[c*ADC_WIDTH +: ADC_WIDTH]);
            mean_d[c*ADC_WIDTH +: ADC_WIDTH] = acc_d[c][LOG2_SAMPS +: ADC_WIDTH];
        end
        last_s = (cnt_q == LAST_CNT);
        load_s = (state_q == ST_ACC) && bus.en && bus.in_valid && last_s;
    end

    // Window FSM, accumulators and the result/handshake registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cont_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        state_q   <= ST_ACC;
                        cont_q    <= bus.continuous;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (!bus.en) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
                    end else if (bus.in_valid) begin
                        if (last_s) begin
                            cnt_q <= '0;
                            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
                            if (!cont_q) begin
                                state_q <= ST_HOLD;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.en) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
                end
            endcase

            // A fresh result wins over a same-edge transfer; it only overruns if unconsumed.
            if (load_s) begin
                data_out_q  <= mean_d;
                out_valid_q <= 1'b1;
                if (out_valid_q && !bus.out_ready) overrun_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_adc_average_multi.sv
// Scoreboard bench for adc_average_multi with 2 channels, 4-sample windows, signed and unsigned
// instances driven in parallel; transfers on the signed instance pop the expected-result queue.
module tb_adc_average_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [23:0] sb [$];

    always #5 clk = ~clk;

    adc_average_multi_if #(.ADC_WIDTH(12), .NUM_CH(2)) s_if ();
    adc_average_multi_if #(.ADC_WIDTH(12), .NUM_CH(2)) u_if ();

    adc_average_multi #(.ADC_WIDTH(12), .NUM_CH(2), .LOG2_SAMPS(2), .SIGNED_IN(1'b1)) dut_s (
        .clk_i(clk), .rst_i(rst), .bus(s_if.slave)
    );
    adc_average_multi #(.ADC_WIDTH(12), .NUM_CH(2), .LOG2_SAMPS(2), .SIGNED_IN(1'b0)) dut_u (
        .clk_i(clk), .rst_i(rst), .bus(u_if.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic en, input logic cont, input logic rdy);
        s_if.en = en;  s_if.continuous = cont;  s_if.out_ready = rdy;
        u_if.en = en;  u_if.continuous = cont;  u_if.out_ready = rdy;
    endtask

    task automatic sample(input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c1u,
                          input logic v);
        s_if.data_in = {c1, c0};   s_if.in_valid = v;
        u_if.data_in = {c1u, c0};  u_if.in_valid = v;
        tick();
    endtask

    task automatic start(input logic cont, input logic rdy);
        set_ctl(1'b1, cont, rdy);
        s_if.in_valid = 1'b0;
        u_if.in_valid = 1'b0;
        tick();
        check_eq("start_busy", {31'd0, s_if.busy}, 32'd1);
    endtask

    // Every transfer on the signed instance must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && s_if.out_valid && s_if.out_ready) begin
            check_eq("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) check_eq("sb_data", {8'd0, s_if.data_out}, {8'd0, sb.pop_front()});
        end
    end

    initial begin
        logic [11:0] gap_d [7];
        logic        gap_v [7];
        set_ctl(1'b0, 1'b0, 1'b1);
        s_if.data_in = '0;  s_if.in_valid = 1'b0;
        u_if.data_in = '0;  u_if.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid",   {31'd0, s_if.out_valid}, 32'd0);
        check_eq("rst_data",    {8'd0, s_if.data_out},   32'd0);
        check_eq("rst_busy",    {31'd0, s_if.busy},      32'd0);
        check_eq("rst_overrun", {31'd0, s_if.overrun},   32'd0);

        // Constant inputs: 100 and -5.
        start(1'b0, 1'b1);
        sb.push_back({12'hFFB, 12'd100});
        for (int i = 0; i < 3; i++) sample(12'd100, 12'hFFB, 12'hFFB, 1'b1);
        check_eq("const_early", {31'd0, s_if.out_valid}, 32'd0);
        sample(12'd100, 12'hFFB, 12'hFFB, 1'b1);
        check_eq("const_valid", {31'd0, s_if.out_valid}, 32'd1);
        check_eq("const_hold",  {31'd0, s_if.busy},      32'd0);
        sample(12'd0, 12'd0, 12'd0, 1'b0);
        check_eq("const_pulse", {31'd0, s_if.out_valid}, 32'd0);
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();

        // Truncation toward minus infinity, signed and unsigned.
        start(1'b0, 1'b1);
        sb.push_back({12'hFFE, 12'd2});
        sample(12'd1, 12'hFFF, 12'hFFF, 1'b1);
        sample(12'd2, 12'hFFF, 12'hFFF, 1'b1);
        sample(12'd3, 12'hFFF, 12'hFFF, 1'b1);
        sample(12'd4, 12'hFFE, 12'hFFF, 1'b1);
        check_eq("trunc_valid", {31'd0, s_if.out_valid}, 32'd1);
        check_eq("uns_valid",   {31'd0, u_if.out_valid}, 32'd1);
        check_eq("uns_data",    {8'd0, u_if.data_out},   {8'd0, 12'hFFF, 12'd2});
        sample(12'd0, 12'd0, 12'd0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();

        // Gapped input; junk on idle cycles must be ignored.
        gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gap_d = '{12'd8, 12'h7FF, 12'h5A5, 12'd8, 12'd8, 12'h123, 12'd12};
        start(1'b0, 1'b1);
        sb.push_back({12'd0, 12'd9});
        for (int i = 0; i < 7; i++) begin
            sample(gap_d[i], 12'd0, 12'd0, gap_v[i]);
            if (i == 5) check_eq("gap_early", {31'd0, s_if.out_valid}, 32'd0);
        end
        check_eq("gap_valid", {31'd0, s_if.out_valid}, 32'd1);
        sample(12'd0, 12'd0, 12'd0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();

        // Continuous windows into a stalled consumer.
        start(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sample(12'd4, 12'd0, 12'd0, 1'b1);
        check_eq("cont_first",    {8'd0, s_if.data_out},   {8'd0, 12'd0, 12'd4});
        check_eq("cont_ovr0",     {31'd0, s_if.overrun},   32'd0);
        check_eq("cont_busy",     {31'd0, s_if.busy},      32'd1);
        sb.push_back({12'd0, 12'd8});
        for (int i = 0; i < 4; i++) sample(12'd8, 12'd0, 12'd0, 1'b1);
        check_eq("cont_second",   {8'd0, s_if.data_out},   {8'd0, 12'd0, 12'd8});
        check_eq("cont_ovr1",     {31'd0, s_if.overrun},   32'd1);
        check_eq("cont_held",     {31'd0, s_if.out_valid}, 32'd1);
        s_if.in_valid = 1'b0;  u_if.in_valid = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b1);
        tick();
        check_eq("cont_drained",  {31'd0, s_if.out_valid}, 32'd0);
        check_eq("cont_sticky",   {31'd0, s_if.overrun},   32'd1);
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();
        check_eq("idle_sticky",   {31'd0, s_if.overrun},   32'd1);
        set_ctl(1'b1, 1'b0, 1'b1);
        tick();
        check_eq("restart_clear", {31'd0, s_if.overrun},   32'd0);
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();

        // Abort mid-window, then a clean window of 20.
        start(1'b0, 1'b1);
        sample(12'd50, 12'd50, 12'd50, 1'b1);
        sample(12'd50, 12'd50, 12'd50, 1'b1);
        s_if.in_valid = 1'b0;  u_if.in_valid = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();
        check_eq("abort_busy",  {31'd0, s_if.busy},      32'd0);
        check_eq("abort_valid", {31'd0, s_if.out_valid}, 32'd0);
        start(1'b0, 1'b1);
        sb.push_back({12'd20, 12'd20});
        for (int i = 0; i < 4; i++) sample(12'd20, 12'd20, 12'd20, 1'b1);
        check_eq("clean_valid", {31'd0, s_if.out_valid}, 32'd1);
        sample(12'd0, 12'd0, 12'd0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b1);
        tick();

        // Reset with a pending result and a partial window.
        start(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sample(12'd7, 12'd7, 12'd7, 1'b1);
        check_eq("pend_valid", {31'd0, s_if.out_valid}, 32'd1);
        sample(12'd3, 12'd3, 12'd3, 1'b1);
        sample(12'd3, 12'd3, 12'd3, 1'b1);
        rst = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0);
        s_if.in_valid = 1'b0;  u_if.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rrst_valid",   {31'd0, s_if.out_valid}, 32'd0);
        check_eq("rrst_data",    {8'd0, s_if.data_out},   32'd0);
        check_eq("rrst_busy",    {31'd0, s_if.busy},      32'd0);
        check_eq("rrst_overrun", {31'd0, s_if.overrun},   32'd0);
        check_eq("rrst_uvalid",  {31'd0, u_if.out_valid}, 32'd0);
        tick();
        check_eq("rrst_idle",    {31'd0, s_if.busy},      32'd0);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
